// File: rtl/svc_axi_bram_if.sv
// AXI4 subordinate bus bundle for svc_axi_bram.
// The slave modport faces the memory; the master modport faces the initiator.
interface svc_axi_bram_if #(
   parameter int AXI_ADDR_WIDTH = 10,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int AXI_ID_WIDTH   = 4
);
   localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

   logic                      s_axi_awvalid;
   logic                      s_axi_awready;
   logic [AXI_ID_WIDTH-1:0]   s_axi_awid;
   logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
   logic [7:0]                s_axi_awlen;
   logic [2:0]                s_axi_awsize;
   logic [1:0]                s_axi_awburst;

   logic                      s_axi_wvalid;
   logic                      s_axi_wready;
   logic [AXI_DATA_WIDTH-1:0] s_axi_wdata;
   logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb;
   logic                      s_axi_wlast;

   logic                      s_axi_bvalid;
   logic                      s_axi_bready;
   logic [AXI_ID_WIDTH-1:0]   s_axi_bid;
   logic [1:0]                s_axi_bresp;

   logic                      s_axi_arvalid;
   logic                      s_axi_arready;
   logic [AXI_ID_WIDTH-1:0]   s_axi_arid;
   logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
   logic [7:0]                s_axi_arlen;
   logic [2:0]                s_axi_arsize;
   logic [1:0]                s_axi_arburst;

   logic                      s_axi_rvalid;
   logic                      s_axi_rready;
   logic [AXI_ID_WIDTH-1:0]   s_axi_rid;
   logic [AXI_DATA_WIDTH-1:0] s_axi_rdata;
   logic [1:0]                s_axi_rresp;
   logic                      s_axi_rlast;

   modport slave (
      input  s_axi_awvalid, s_axi_awid, s_axi_awaddr,
      input  s_axi_awlen, s_axi_awsize, s_axi_awburst,
      output s_axi_awready,
      input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      output s_axi_wready,
      output s_axi_bvalid, s_axi_bid, s_axi_bresp,
      input  s_axi_bready,
      input  s_axi_arvalid, s_axi_arid, s_axi_araddr,
      input  s_axi_arlen, s_axi_arsize, s_axi_arburst,
      output s_axi_arready,
      output s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
      input  s_axi_rready
   );

   modport master (
      output s_axi_awvalid, s_axi_awid, s_axi_awaddr,
      output s_axi_awlen, s_axi_awsize, s_axi_awburst,
      input  s_axi_awready,
      output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      input  s_axi_wready,
      input  s_axi_bvalid, s_axi_bid, s_axi_bresp,
      output s_axi_bready,
      output s_axi_arvalid, s_axi_arid, s_axi_araddr,
      output s_axi_arlen, s_axi_arsize, s_axi_arburst,
      input  s_axi_arready,
      input  s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
      output s_axi_rready
   );
endinterface

// File: rtl/svc_axi_bram.sv
// AXI4 subordinate over inferred block RAM, one burst in flight per channel.
// Define SVC_AXI_BRAM_ERR_EN to report SLVERR on WRAP, bad size or bad wlast.
module svc_axi_bram #(
   parameter int AXI_ADDR_WIDTH = 10,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int MEM_DEPTH      =
      2 ** (AXI_ADDR_WIDTH - $clog2(AXI_STRB_WIDTH))
) (
   input logic             clk,
   input logic             rst_n,
   svc_axi_bram_if.slave   s_axi
);
   localparam int LSB = $clog2(AXI_STRB_WIDTH);
   localparam int XW  = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   w_state_t                w_state, w_next;
   r_state_t                r_state, r_next;
   logic                    ready_en;

   logic [AXI_ID_WIDTH-1:0] w_id;
   logic [XW-1:0]           w_idx;
   logic [7:0]              w_len, w_cnt;
   logic                    w_fixed, w_err;

   logic [AXI_ID_WIDTH-1:0] r_id;
   logic [XW-1:0]           r_idx;
   logic [7:0]              r_len, r_cnt;
   logic                    r_fixed, r_err, r_done;

   logic                      ram_valid, ram_last;
   logic [AXI_DATA_WIDTH-1:0] ram_data;
   logic                      skid_valid, skid_last;
   logic [AXI_DATA_WIDTH-1:0] skid_data;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic rd_issue, skid_load, rvalid_i, rlast_i;
   logic aw_bad, w_bad, ar_bad;
   logic unused_ok;

   assign aw_hs = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
   assign w_hs  = s_axi.s_axi_wvalid && s_axi.s_axi_wready;
   assign b_hs  = s_axi.s_axi_bvalid && s_axi.s_axi_bready;
   assign ar_hs = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
   assign r_hs  = rvalid_i && s_axi.s_axi_rready;

`ifdef SVC_AXI_BRAM_ERR_EN
   assign aw_bad = (s_axi.s_axi_awburst == 2'b10) ||
                   (s_axi.s_axi_awsize != 3'(LSB));
   assign w_bad  = s_axi.s_axi_wlast != (w_cnt == w_len);
   assign ar_bad = (s_axi.s_axi_arburst == 2'b10) ||
                   (s_axi.s_axi_arsize != 3'(LSB));
`else
   assign aw_bad = 1'b0;
   assign w_bad  = 1'b0;
   assign ar_bad = 1'b0;
`endif

   assign unused_ok = ^{s_axi.s_axi_awaddr, s_axi.s_axi_araddr,
                        s_axi.s_axi_awsize, s_axi.s_axi_arsize,
                        s_axi.s_axi_wlast};

   // Write channel
   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && w_cnt == w_len) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         w_state  <= W_IDLE;
         w_id     <= '0;
         w_idx    <= '0;
         w_len    <= '0;
         w_cnt    <= '0;
         w_fixed  <= 1'b0;
         w_err    <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         w_state  <= w_next;
         if (aw_hs) begin
            w_id    <= s_axi.s_axi_awid;
            w_idx   <= s_axi.s_axi_awaddr[LSB +: XW];
            w_len   <= s_axi.s_axi_awlen;
            w_cnt   <= '0;
            w_fixed <= s_axi.s_axi_awburst == 2'b00;
            w_err   <= aw_bad;
         end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed) w_idx <= w_idx + 1'b1;
            if (w_bad) w_err <= 1'b1;
         end
      end
   end

   assign s_axi.s_axi_awready = ready_en && w_state == W_IDLE;
   assign s_axi.s_axi_wready  = w_state == W_DATA;
   assign s_axi.s_axi_bvalid  = w_state == W_RESP;
   assign s_axi.s_axi_bid     = w_id;
   assign s_axi.s_axi_bresp   = {w_err, 1'b0};

   // Read channel: BRAM output register backed by a one-entry skid
   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_BURST;
         R_BURST: if (r_hs && rlast_i) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   assign rd_issue  = r_state == R_BURST && !r_done && !skid_valid;
   assign skid_load = rd_issue && ram_valid && !r_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= R_IDLE;
         r_id       <= '0;
         r_idx      <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_fixed    <= 1'b0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
         ram_valid  <= 1'b0;
         ram_last   <= 1'b0;
         skid_valid <= 1'b0;
         skid_last  <= 1'b0;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            r_id    <= s_axi.s_axi_arid;
            r_idx   <= s_axi.s_axi_araddr[LSB +: XW];
            r_len   <= s_axi.s_axi_arlen;
            r_cnt   <= '0;
            r_fixed <= s_axi.s_axi_arburst == 2'b00;
            r_err   <= ar_bad;
            r_done  <= 1'b0;
         end else if (rd_issue) begin
            r_cnt <= r_cnt + 8'd1;
            if (!r_fixed) r_idx <= r_idx + 1'b1;
            if (r_cnt == r_len) r_done <= 1'b1;
         end
         if (rd_issue) begin
            ram_valid <= 1'b1;
            ram_last  <= r_cnt == r_len;
         end else if (!skid_valid && r_hs) begin
            ram_valid <= 1'b0;
         end
         if (skid_load) begin
            skid_valid <= 1'b1;
            skid_last  <= ram_last;
         end else if (skid_valid && r_hs) begin
            skid_valid <= 1'b0;
         end
      end
   end

   // Non-blocking read and write of the array give read-first collisions
   always_ff @(posedge clk) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
         if (w_hs && s_axi.s_axi_wstrb[b])
            mem[w_idx][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
      end
      if (rd_issue) ram_data <= mem[r_idx];
      if (skid_load) skid_data <= ram_data;
   end

   assign rvalid_i            = skid_valid || ram_valid;
   assign rlast_i             = skid_valid ? skid_last : ram_last;
   assign s_axi.s_axi_rvalid  = rvalid_i;
   assign s_axi.s_axi_rlast   = rlast_i;
   assign s_axi.s_axi_rdata   = skid_valid ? skid_data : ram_data;
   assign s_axi.s_axi_rid     = r_id;
   assign s_axi.s_axi_rresp   = {r_err, 1'b0};
   assign s_axi.s_axi_arready = ready_en && r_state == R_IDLE;
endmodule

// File: tb/tb_svc_axi_bram.sv
// Directed and randomized bench for svc_axi_bram with a word-array model.
// Expected read data is taken from the model snapshot at burst start.
module tb_svc_axi_bram;
   localparam int DEPTH = 512;
   localparam logic [1:0] SLV =
`ifdef SVC_AXI_BRAM_ERR_EN
      2'b10;
`else
      2'b00;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   svc_axi_bram_if #(.AXI_ADDR_WIDTH(10), .AXI_DATA_WIDTH(16),
                     .AXI_ID_WIDTH(4)) bus ();

   svc_axi_bram #(.AXI_ADDR_WIDTH(10), .AXI_DATA_WIDTH(16),
                  .AXI_ID_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .s_axi(bus));

   int checks = 0;
   int errors = 0;

   logic [15:0] ref_mem [DEPTH];
   int          p_idx[$];
   logic [15:0] p_dat[$];
   logic [1:0]  p_stb[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void apply_pending();
      foreach (p_idx[i])
         for (int b = 0; b < 2; b++)
            if (p_stb[i][b]) ref_mem[p_idx[i]][8*b +: 8] = p_dat[i][8*b +: 8];
      p_idx.delete();
      p_dat.delete();
      p_stb.delete();
   endfunction

   task automatic aw_req(input logic [3:0] id, input logic [9:0] addr,
                         input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size);
      int n = 0;
      bus.s_axi_awvalid = 1'b1;
      bus.s_axi_awid    = id;
      bus.s_axi_awaddr  = addr;
      bus.s_axi_awlen   = len;
      bus.s_axi_awsize  = size;
      bus.s_axi_awburst = burst;
      while (!bus.s_axi_awready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) chk("aw_wait", n, 0);
      @(posedge clk); #1;
      bus.s_axi_awvalid = 1'b0;
   endtask

   task automatic ar_req(input logic [3:0] id, input logic [9:0] addr,
                         input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size);
      int n = 0;
      bus.s_axi_arvalid = 1'b1;
      bus.s_axi_arid    = id;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arlen   = len;
      bus.s_axi_arsize  = size;
      bus.s_axi_arburst = burst;
      while (!bus.s_axi_arready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) chk("ar_wait", n, 0);
      @(posedge clk); #1;
      bus.s_axi_arvalid = 1'b0;
   endtask

   // stb == 0 selects a random nonzero strobe per beat
   task automatic wr_beats(input logic [3:0] id, input logic [9:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input int bad_last, input bit use_d0,
                           input logic [15:0] d0, input logic [1:0] stb,
                           input logic [1:0] eresp, input bit upd);
      int base, n;
      logic [15:0] d;
      logic [1:0] s;
      base = int'(addr >> 1);
      chk("w_ready_n1", bus.s_axi_wready, 1);
      chk("aw_busy", bus.s_axi_awready, 0);
      for (int k = 0; k <= int'(len); k++) begin
         d = use_d0 ? d0 + 16'(k) : 16'($urandom);
         s = (stb != 2'b00) ? stb : 2'($urandom_range(1, 3));
         bus.s_axi_wvalid = 1'b1;
         bus.s_axi_wdata  = d;
         bus.s_axi_wstrb  = s;
         bus.s_axi_wlast  = (bad_last >= 0) ? (k == bad_last)
                                            : (k == int'(len));
         n = 0;
         while (!bus.s_axi_wready && n < 100) begin
            @(posedge clk); #1; n++;
         end
         if (n >= 100) chk("w_wait", n, 0);
         @(posedge clk); #1;
         p_idx.push_back(burst == 2'b00 ? base : (base + k) % DEPTH);
         p_dat.push_back(d);
         p_stb.push_back(s);
      end
      bus.s_axi_wvalid = 1'b0;
      bus.s_axi_wlast  = 1'b0;
      chk("b_valid_m1", bus.s_axi_bvalid, 1);
      chk("b_id", bus.s_axi_bid, id);
      chk("b_resp", bus.s_axi_bresp, eresp);
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk("b_hold_v", bus.s_axi_bvalid, 1);
         chk("b_hold_id", bus.s_axi_bid, id);
      end
      bus.s_axi_bready = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_bready = 1'b0;
      chk("b_done", bus.s_axi_bvalid, 0);
      chk("aw_ready_back", bus.s_axi_awready, 1);
      if (upd) apply_pending();
   endtask

   task automatic rd_beats(input logic [3:0] id, input logic [9:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input bit rnd, input logic [1:0] eresp);
      logic [15:0] exp[$];
      int base, got, cyc;
      bit stall;
      logic [15:0] sd;
      logic sl;
      base = int'(addr >> 1);
      for (int k = 0; k <= int'(len); k++)
         exp.push_back(ref_mem[burst == 2'b00 ? base : (base + k) % DEPTH]);
      got = 0;
      cyc = 1;
      stall = 0;
      sd = '0;
      sl = 1'b0;
      chk("r_n1_idle", bus.s_axi_rvalid, 0);
      while (got <= int'(len) && cyc < 4000) begin
         bus.s_axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall) begin
            chk("r_hold_v", bus.s_axi_rvalid, 1);
            chk("r_hold_d", bus.s_axi_rdata, sd);
            chk("r_hold_l", bus.s_axi_rlast, sl);
         end
         stall = 0;
         if (bus.s_axi_rvalid) begin
            if (bus.s_axi_rready) begin
               chk("r_data", bus.s_axi_rdata, exp[got]);
               chk("r_last", bus.s_axi_rlast, got == int'(len));
               chk("r_id", bus.s_axi_rid, id);
               chk("r_resp", bus.s_axi_rresp, eresp);
               if (!rnd) chk("r_timing", cyc, got + 2);
               got++;
            end else begin
               stall = 1;
               sd = bus.s_axi_rdata;
               sl = bus.s_axi_rlast;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.s_axi_rready = 1'b0;
      chk("r_count", got, int'(len) + 1);
      chk("ar_ready_back", bus.s_axi_arready, 1);
   endtask

   task automatic wr(input logic [3:0] id, input logic [9:0] addr,
                     input logic [7:0] len, input logic [1:0] burst,
                     input logic [2:0] size, input int bad_last,
                     input bit use_d0, input logic [15:0] d0,
                     input logic [1:0] stb, input logic [1:0] eresp);
      aw_req(id, addr, len, burst, size);
      wr_beats(id, addr, len, burst, bad_last, use_d0, d0, stb, eresp, 1);
   endtask

   task automatic rd(input logic [3:0] id, input logic [9:0] addr,
                     input logic [7:0] len, input logic [1:0] burst,
                     input logic [2:0] size, input bit rnd,
                     input logic [1:0] eresp);
      ar_req(id, addr, len, burst, size);
      rd_beats(id, addr, len, burst, rnd, eresp);
   endtask

   initial begin
      logic [9:0] a;
      logic [7:0] l;
      logic [1:0] bt;
      bus.s_axi_awvalid = 0; bus.s_axi_awid = 0; bus.s_axi_awaddr = 0;
      bus.s_axi_awlen = 0; bus.s_axi_awsize = 0; bus.s_axi_awburst = 0;
      bus.s_axi_wvalid = 0; bus.s_axi_wdata = 0; bus.s_axi_wstrb = 0;
      bus.s_axi_wlast = 0; bus.s_axi_bready = 0;
      bus.s_axi_arvalid = 0; bus.s_axi_arid = 0; bus.s_axi_araddr = 0;
      bus.s_axi_arlen = 0; bus.s_axi_arsize = 0; bus.s_axi_arburst = 0;
      bus.s_axi_rready = 0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", bus.s_axi_awready, 0);
      chk("rst_wready", bus.s_axi_wready, 0);
      chk("rst_bvalid", bus.s_axi_bvalid, 0);
      chk("rst_arready", bus.s_axi_arready, 0);
      chk("rst_rvalid", bus.s_axi_rvalid, 0);
      chk("rst_rlast", bus.s_axi_rlast, 0);
      chk("rst_bresp", bus.s_axi_bresp, 0);
      chk("rst_rresp", bus.s_axi_rresp, 0);
      chk("rst_bid", bus.s_axi_bid, 0);
      chk("rst_rid", bus.s_axi_rid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_arready_pre", bus.s_axi_arready, 0);
      @(posedge clk); #1;
      chk("rel_arready", bus.s_axi_arready, 1);
      chk("rel_awready", bus.s_axi_awready, 1);

      // Single write then read
      wr(4'd3, 10'h010, 8'd0, 2'b01, 3'd1, -1, 1, 16'hBEEF, 2'b11, 2'b00);
      rd(4'd5, 10'h010, 8'd0, 2'b01, 3'd1, 0, 2'b00);

      // Fill the whole array so later strobes merge into known data
      wr(4'd1, 10'h000, 8'd255, 2'b01, 3'd1, -1, 0, 16'h0, 2'b11, 2'b00);
      wr(4'd1, 10'h200, 8'd255, 2'b01, 3'd1, -1, 0, 16'h0, 2'b11, 2'b00);
      rd(4'd2, 10'h100, 8'd255, 2'b01, 3'd1, 0, 2'b00);

      // INCR burst of 0..7
      wr(4'd1, 10'h020, 8'd7, 2'b01, 3'd1, -1, 1, 16'h0000, 2'b11, 2'b00);
      rd(4'd9, 10'h020, 8'd7, 2'b01, 3'd1, 0, 2'b00);

      // Byte strobe merge
      wr(4'd4, 10'h030, 8'd0, 2'b01, 3'd1, -1, 1, 16'h1234, 2'b11, 2'b00);
      wr(4'd4, 10'h030, 8'd0, 2'b01, 3'd1, -1, 1, 16'hABCD, 2'b01, 2'b00);
      rd(4'd4, 10'h030, 8'd0, 2'b01, 3'd1, 0, 2'b00);

      // Backpressure
      rd(4'd6, 10'h0A0, 8'd15, 2'b01, 3'd1, 1, 2'b00);

      // Concurrent write and read bursts over the same words
      bus.s_axi_awvalid = 1; bus.s_axi_awid = 4'd6; bus.s_axi_awaddr = 10'h060;
      bus.s_axi_awlen = 8'd7; bus.s_axi_awsize = 3'd1; bus.s_axi_awburst = 2'b01;
      bus.s_axi_arvalid = 1; bus.s_axi_arid = 4'd7; bus.s_axi_araddr = 10'h060;
      bus.s_axi_arlen = 8'd7; bus.s_axi_arsize = 3'd1; bus.s_axi_arburst = 2'b01;
      chk("both_ready", {bus.s_axi_awready, bus.s_axi_arready}, 2'b11);
      @(posedge clk); #1;
      bus.s_axi_awvalid = 0;
      bus.s_axi_arvalid = 0;
      fork
         wr_beats(4'd6, 10'h060, 8'd7, 2'b01, -1, 0, 16'h0, 2'b11, 2'b00, 0);
         rd_beats(4'd7, 10'h060, 8'd7, 2'b01, 0, 2'b00);
      join
      apply_pending();
      rd(4'd7, 10'h060, 8'd7, 2'b01, 3'd1, 1, 2'b00);

      // FIXED write leaves the last beat
      wr(4'd2, 10'h040, 8'd3, 2'b00, 3'd1, -1, 0, 16'h0, 2'b11, 2'b00);
      rd(4'd2, 10'h040, 8'd0, 2'b01, 3'd1, 0, 2'b00);
      rd(4'd2, 10'h040, 8'd3, 2'b00, 3'd1, 1, 2'b00);

      // Index wraps past the top of the array
      wr(4'd8, 10'h3FC, 8'd3, 2'b01, 3'd1, -1, 0, 16'h0, 2'b00, 2'b00);
      rd(4'd8, 10'h3FC, 8'd3, 2'b01, 3'd1, 0, 2'b00);

      for (int i = 0; i < 8; i++) begin
         a  = 10'($urandom);
         l  = 8'($urandom_range(0, 15));
         bt = 2'($urandom_range(0, 1));
         wr(4'($urandom), a, l, bt, 3'd1, -1, 0, 16'h0, 2'b00, 2'b00);
         rd(4'($urandom), a, l, bt, 3'd1, i[0], 2'b00);
      end

      // Protocol violations
      wr(4'd5, 10'h080, 8'd1, 2'b10, 3'd1, -1, 0, 16'h0, 2'b11, SLV);
      wr(4'd5, 10'h090, 8'd3, 2'b01, 3'd1, 1, 0, 16'h0, 2'b11, SLV);
      wr(4'd5, 10'h0B0, 8'd0, 2'b01, 3'd0, -1, 0, 16'h0, 2'b11, SLV);
      rd(4'd5, 10'h080, 8'd3, 2'b10, 3'd1, 0, SLV);
      rd(4'd5, 10'h090, 8'd1, 2'b01, 3'd0, 0, SLV);
      wr(4'd5, 10'h0C0, 8'd1, 2'b01, 3'd1, -1, 0, 16'h0, 2'b11, 2'b00);

      // Reset in the middle of a read burst
      ar_req(4'd3, 10'h0C0, 8'd15, 2'b01, 3'd1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("mid_rvalid", bus.s_axi_rvalid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rvalid", bus.s_axi_rvalid, 0);
      chk("mid_rst_arready", bus.s_axi_arready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_pre", bus.s_axi_arready, 0);
      @(posedge clk); #1;
      chk("mid_rel_arready", bus.s_axi_arready, 1);
      chk("mid_rel_rvalid", bus.s_axi_rvalid, 0);
      rd(4'd3, 10'h0C0, 8'd15, 2'b01, 3'd1, 0, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
